// File: rtl/usr_pkg.sv
`default_nettype none
// =============================================================================
// Module   : usr_pkg
// Brief    : Shared mode encodings, direction constants and FSM state type
//            for the universal shift register.
// Revision : 1.0
// =============================================================================
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/usr_shift_cnt.sv
`default_nettype none
// =============================================================================
// Module   : usr_shift_cnt
// Brief    : Loadable down-counter that saturates at zero; tc flags a count of 1.
// Revision : 1.0
// =============================================================================
module usr_shift_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // tc marks the edge that performs the final shift of a sequence.
    assign tc = (cnt_q == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// =============================================================================
// Module   : univ_shift_reg
// Brief    : Universal shift register with manual modes and a start-triggered
//            WIDTH-step auto-shift. Define UNIV_SHIFT_REG_ROTATE_EN for rot input.
// Revision : 1.0
// =============================================================================
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic             dir,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_tc;

    logic             fill_r;
    logic             fill_l;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] shl;
    logic             act_left;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    // Rotation recirculates the bit leaving the opposite end.
    assign fill_r = rot ? q_q[0]       : sin_r;
    assign fill_l = rot ? q_q[WIDTH-1] : sin_l;
`else
    assign fill_r = sin_r;
    assign fill_l = sin_l;
`endif

    assign shr = {fill_r, q_q[WIDTH-1:1]};
    assign shl = {q_q[WIDTH-2:0], fill_l};

    usr_shift_cnt #(
        .CNT_W (CNT_W)
    ) u_shift_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CNT_W'(WIDTH)),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        dir_d    = dir_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    q_d      = d;
                    dir_d    = dir;
                    cnt_load = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_SHIFT;
                end else begin
                    case (mode)
                        MODE_HOLD: q_d = q_q;
                        MODE_SHR:  q_d = shr;
                        MODE_SHL:  q_d = shl;
                        MODE_LOAD: q_d = d;
                    endcase
                end
            end
            ST_SHIFT: begin
                q_d     = (dir_q == DIR_LEFT) ? shl : shr;
                cnt_dec = 1'b1;
                if (cnt_tc) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            dir_q   <= DIR_RIGHT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Idle follows the manual mode; a running sequence follows its latched direction.
    assign act_left = (state_q == ST_SHIFT) ? (dir_q == DIR_LEFT) : (mode == MODE_SHL);

    assign q    = q_q;
    assign qb   = ~q_q;
    assign sout = act_left ? q_q[WIDTH-1] : q_q[0];
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// =============================================================================
// Module   : tb_univ_shift_reg
// Brief    : Directed scoreboard bench for univ_shift_reg (WIDTH=8).
// Revision : 1.0
// =============================================================================
module tb_univ_shift_reg;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] mode  = 2'b00;
    logic [7:0] d     = 8'h00;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;
    logic       start = 1'b0;
    logic       dir   = 1'b0;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    logic       rot   = 1'b0;
`endif
    logic [7:0] q;
    logic [7:0] qb;
    logic       sout;
    logic       busy;
    logic       done;

    univ_shift_reg #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .d     (d),
        .sin_r (sin_r),
        .sin_l (sin_l),
        .start (start),
        .dir   (dir),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        .rot   (rot),
`endif
        .q     (q),
        .qb    (qb),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] q;
        logic       busy;
        logic       done;
        logic       sout;
    } exp_t;

    exp_t edge_q[$];
    exp_t async_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input exp_t e);
        logic bad;
        bad = 1'b0;
        n_vec++;
        if (q !== e.q) begin
            $display("FAIL %s q: got %h want %h", e.name, q, e.q); bad = 1'b1;
        end
        if (qb !== ~e.q) begin
            $display("FAIL %s qb: got %h want %h", e.name, qb, ~e.q); bad = 1'b1;
        end
        if (busy !== e.busy) begin
            $display("FAIL %s busy: got %b want %b", e.name, busy, e.busy); bad = 1'b1;
        end
        if (done !== e.done) begin
            $display("FAIL %s done: got %b want %b", e.name, done, e.done); bad = 1'b1;
        end
        if (sout !== e.sout) begin
            $display("FAIL %s sout: got %b want %b", e.name, sout, e.sout); bad = 1'b1;
        end
        if (bad) n_miss++;
    endtask

    // Edge monitor: one scoreboard entry per rising edge, sampled just after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (edge_q.size() > 0) check(edge_q.pop_front());
        end
    end

    // Reset monitor: outputs must respond to reset without any clock edge.
    initial begin
        forever begin
            @(posedge reset);
            #1;
            if (async_q.size() > 0) check(async_q.pop_front());
        end
    end

    function automatic exp_t mk(input string nm, input logic [7:0] eq, input logic eb,
                                input logic ed, input logic es);
        exp_t e;
        e.name = nm; e.q = eq; e.busy = eb; e.done = ed; e.sout = es;
        return e;
    endfunction

    // Apply one cycle of inputs and queue the state expected after the next edge.
    task automatic drive(input logic [1:0] m, input logic [7:0] dv, input logic sr,
                         input logic sl, input logic st, input logic dr, input string nm,
                         input logic [7:0] eq, input logic eb, input logic ed, input logic es);
        mode = m; d = dv; sin_r = sr; sin_l = sl; start = st; dir = dr;
        edge_q.push_back(mk(nm, eq, eb, ed, es));
        @(posedge clk);
        #2;
    endtask

    // Raise reset mid-cycle and expect the cleared state before any edge.
    task automatic async_reset(input string nm, input int dly);
        async_q.push_back(mk(nm, 8'h00, 1'b0, 1'b0, 1'b0));
        #(dly);
        reset = 1'b1;
        @(posedge clk);
        #2;
    endtask

    logic [7:0] seq_r   [8] = '{8'h81, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic       sout_r  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] seq_ig  [8] = '{8'h0F, 8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    logic       sout_ig [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] seq_l   [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] seq_mid [4] = '{8'hF0, 8'hF8, 8'hFC, 8'hFE};
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    logic [7:0] seq_rot [8] = '{8'h3C, 8'h78, 8'hF0, 8'hE1, 8'hC3, 8'h87, 8'h0F, 8'h1E};
    logic       sout_rot[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-up reset, checked between edges, then held across one edge.
        async_reset("por_async", 2);
        drive(2'b11, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, "por_held", 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Manual operations.
        drive(2'b11, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "man_load", 8'hA5, 1'b0, 1'b0, 1'b1);
        drive(2'b01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "man_shr",  8'hD2, 1'b0, 1'b0, 1'b0);
        drive(2'b10, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "man_shl",  8'hA4, 1'b0, 1'b0, 1'b1);
        drive(2'b00, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, "man_hold", 8'hA4, 1'b0, 1'b0, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "man_hold2", 8'hA4, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a clock period.
        async_reset("mid_cycle_async", 3);
        drive(2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, "mid_cycle_held", 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Auto right shift of 0x81; mode toggled to prove it is ignored.
        drive(2'b00, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, "autor_0", seq_r[0], 1'b1, 1'b0, sout_r[0]);
        for (int i = 1; i < 8; i++)
            drive(2'b10, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, $sformatf("autor_%0d", i),
                  seq_r[i], 1'b1, 1'b0, sout_r[i]);
        drive(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "autor_done", 8'h00, 1'b0, 1'b1, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "autor_after", 8'h00, 1'b0, 1'b0, 1'b0);

        // Start pulses during SHIFT, including on the final edge, are ignored.
        for (int i = 0; i < 8; i++)
            drive(2'b00, (i == 0) ? 8'h0F : 8'hFF, 1'b1, 1'b0, (i == 0) || (i == 2),
                  (i == 0), $sformatf("ign_%0d", i), seq_ig[i], 1'b1, 1'b0, sout_ig[i]);
        drive(2'b00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, "ign_done", 8'h00, 1'b0, 1'b1, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "ign_after", 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset after three shifts aborts without a done pulse.
        for (int i = 0; i < 4; i++)
            drive(2'b00, 8'hF0, 1'b1, 1'b0, (i == 0), 1'b0, $sformatf("mid_%0d", i),
                  seq_mid[i], 1'b1, 1'b0, 1'b0);
        async_reset("mid_seq_async", 3);
        drive(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "mid_seq_held", 8'h00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        drive(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "mid_seq_idle0", 8'h00, 1'b0, 1'b0, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "mid_seq_idle1", 8'h00, 1'b0, 1'b0, 1'b0);

        // A fresh sequence afterwards runs all eight left shifts.
        for (int i = 0; i < 8; i++)
            drive(2'b00, 8'h01, 1'b0, 1'b0, (i == 0), 1'b1, $sformatf("restart_%0d", i),
                  seq_l[i], 1'b1, 1'b0, (i == 7));
        drive(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "restart_done", 8'h00, 1'b0, 1'b1, 1'b0);
        drive(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "restart_after", 8'h00, 1'b0, 1'b0, 1'b0);

`ifdef UNIV_SHIFT_REG_ROTATE_EN
        // Auto left rotate of 0x3C returns to 0x3C; then manual right rotates.
        rot = 1'b1;
        for (int i = 0; i < 8; i++)
            drive(2'b00, 8'h3C, 1'b0, 1'b0, (i == 0), 1'b1, $sformatf("rot_%0d", i),
                  seq_rot[i], 1'b1, 1'b0, sout_rot[i]);
        drive(2'b00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "rot_done", 8'h3C, 1'b0, 1'b1, 1'b0);
        drive(2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "rot_shr0", 8'h1E, 1'b0, 1'b0, 1'b0);
        drive(2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "rot_shr1", 8'h0F, 1'b0, 1'b0, 1'b1);
        drive(2'b01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "rot_shr2", 8'h87, 1'b0, 1'b0, 1'b1);
        rot = 1'b0;
`endif

        for (int i = 0; i < 10 && edge_q.size() > 0; i++) @(posedge clk);
        #3;
        if (edge_q.size() > 0 || async_q.size() > 0) begin
            $display("FAIL drain: got %0d pending want 0", edge_q.size() + async_q.size());
            n_miss++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
